// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM states,
// access-size encodings, and the default IO region tag.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] IO_REGION_HI = 2'b11;

    // Unused encoding 3 is treated as a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates icache refills and LSB accesses onto a byte-wide synchronous RAM,
// serializing each access into per-byte cycles. Optional macro MEMCTRL_IO_STALL_EN
// stalls IO-region store bytes while the IO output buffer is full.
//
//   state  | meaning
//   IDLE   | waiting; LSB request has priority over icache
//   IFETCH | 4-byte instruction read, abortable by jump_wrong
//   LOAD   | 1/2/4-byte data read, zero-extended
//   STORE  | 1/2/4-byte data write, low byte first
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_REGION_HI
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              icache_req,
    input  logic [31:0]       icache_addr,
    output logic              icache_valid,
    output logic [31:0]       icache_instr,
    input  logic              jump_wrong,
    input  logic              lsb_req,
    input  logic              lsb_wr,
    input  logic [1:0]        lsb_size,
    input  logic [31:0]       lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_a_d;
    logic [2:0]        n_q, n_d, cnt_q, cnt_d, cnt_inc, byte_idx;
    logic [31:0]       wdata_q, wdata_d, asm_q, asm_d, merged;
    logic [31:0]       instr_d, rdata_d;
    logic [7:0]        dout_d;
    logic              wr_q, wr_d, ivalid_d, done_d;
    logic              io_stall;

    assign cnt_inc  = cnt_q + 3'd1;
    // In a read, the byte on mem_din during count c belongs to position c-1.
    assign byte_idx = cnt_q - 3'd1;
    assign merged   = asm_q | (32'(mem_din) << {byte_idx[1:0], 3'b000});

`ifdef MEMCTRL_IO_STALL_EN
    assign io_stall = (state_q == STORE) && wr_q && (mem_a[17:16] == IO_HI) && io_buffer_full;
`else
    logic io_unused;
    assign io_stall  = 1'b0;
    assign io_unused = io_buffer_full | (IO_HI == 2'b00);
`endif

    assign mem_wr = wr_q & rdy & ~io_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        asm_d    = asm_q;
        mem_a_d  = mem_a;
        dout_d   = mem_dout;
        wr_d     = 1'b0;
        ivalid_d = 1'b0;
        done_d   = 1'b0;
        instr_d  = icache_instr;
        rdata_d  = lsb_rdata;

        case (state_q)
            IDLE: begin
                if (lsb_req) begin
                    state_d = lsb_wr ? STORE : LOAD;
                    addr_d  = ADDR_W'(lsb_addr);
                    mem_a_d = ADDR_W'(lsb_addr);
                    n_d     = size_to_bytes(lsb_size);
                    cnt_d   = 3'd0;
                    wdata_d = lsb_wdata;
                    asm_d   = 32'd0;
                    if (lsb_wr) begin
                        dout_d = lsb_wdata[7:0];
                        wr_d   = 1'b1;
                    end
                end else if (icache_req) begin
                    state_d = IFETCH;
                    addr_d  = ADDR_W'(icache_addr);
                    mem_a_d = ADDR_W'(icache_addr);
                    n_d     = 3'd4;
                    cnt_d   = 3'd0;
                    asm_d   = 32'd0;
                end
            end

            IFETCH, LOAD: begin
                if (state_q == IFETCH && jump_wrong) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_q != 3'd0) asm_d = merged;
                    if (cnt_inc < n_q) mem_a_d = addr_q + ADDR_W'(cnt_inc);
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        if (state_q == IFETCH) begin
                            ivalid_d = 1'b1;
                            instr_d  = merged;
                        end else begin
                            done_d  = 1'b1;
                            rdata_d = merged;
                        end
                    end
                end
            end

            STORE: begin
                if (io_stall) begin
                    wr_d = 1'b1;
                end else if (cnt_inc < n_q) begin
                    cnt_d   = cnt_inc;
                    mem_a_d = addr_q + ADDR_W'(cnt_inc);
                    dout_d  = 8'(wdata_q >> {cnt_inc[1:0], 3'b000});
                    wr_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            n_q          <= 3'd0;
            cnt_q        <= 3'd0;
            wdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            mem_a        <= '0;
            mem_dout     <= 8'd0;
            wr_q         <= 1'b0;
            icache_valid <= 1'b0;
            lsb_done     <= 1'b0;
            icache_instr <= 32'd0;
            lsb_rdata    <= 32'd0;
        end else if (rdy) begin
            addr_q       <= addr_d;
            n_q          <= n_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            mem_a        <= mem_a_d;
            mem_dout     <= dout_d;
            wr_q         <= wr_d;
            icache_valid <= ivalid_d;
            lsb_done     <= done_d;
            icache_instr <= instr_d;
            lsb_rdata    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, golden byte memory and
// directed plus random accesses.
module tb_mem_ctrl;

    logic        clk;
    logic        rst, rdy;
    logic        icache_req, icache_valid, jump_wrong;
    logic [31:0] icache_addr, icache_instr;
    logic        lsb_req, lsb_wr, lsb_done;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_at = 0, hold_len = 0, io_at = 0, io_len = 0;

    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t        wlog[$];
    logic [7:0] ram    [logic [31:0]];
    logic [7:0] golden [logic [31:0]];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_instr(icache_instr),
        .jump_wrong(jump_wrong),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] t;
        t = (a * 32'd37) ^ (a >> 8);
        return t[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_byte(a);
    endfunction

    // Synchronous RAM, frozen together with the rest of the system when rdy is low.
    initial mem_din = 8'd0;
    always @(posedge clk) begin
        if (rdy) mem_din <= ram_rd(mem_a);
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout});
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_lsb(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
        int          n, exp_lat, lat, base_w, exp_off;
        logic [31:0] exp_data;
        bit          got;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_lat = (wr ? n + 1 : n + 2) + hold_len;
`ifdef MEMCTRL_IO_STALL_EN
        if (wr && addr[17:16] == 2'b11) exp_lat += io_len;
`endif
        exp_data = 32'd0;
        for (int k = 0; k < n; k++) exp_data |= 32'(gold_rd(addr + 32'(k))) << (8 * k);
        base_w = wlog.size();
        lsb_req = 1'b1; lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            rdy = !(hold_len > 0 && i >= hold_at && i < hold_at + hold_len);
            io_buffer_full = (io_len > 0 && i >= io_at && i < io_at + io_len);
            #1;
            if (!rdy) begin
                exp_off = (hold_at - 1 < n - 1) ? hold_at - 1 : n - 1;
                chk(mem_a, addr + 32'(exp_off), {tag, "_rdy_addr_hold"});
                chk(32'(mem_wr), 32'd0, {tag, "_rdy_wr_gate"});
            end
            if (lsb_done) begin
                got = 1'b1; lat = i; lsb_req = 1'b0;
            end
        end
        rdy = 1'b1; io_buffer_full = 1'b0; lsb_req = 1'b0;
        chk(32'(lat), 32'(exp_lat), {tag, "_latency"});
        chk(32'(wlog.size() - base_w), wr ? 32'(n) : 32'd0, {tag, "_write_count"});
        if (wr) begin
            for (int k = 0; k < n && base_w + k < wlog.size(); k++) begin
                chk(wlog[base_w + k].a, addr + 32'(k), {tag, "_write_addr"});
                chk(32'(wlog[base_w + k].d), 32'(8'(wdata >> (8 * k))), {tag, "_write_data"});
            end
            for (int k = 0; k < n; k++) golden[addr + 32'(k)] = 8'(wdata >> (8 * k));
        end else begin
            chk(lsb_rdata, exp_data, {tag, "_rdata"});
        end
        @(negedge clk); #1;
        chk(32'(lsb_done), 32'd0, {tag, "_pulse_width"});
        if (!wr) chk(lsb_rdata, exp_data, {tag, "_rdata_hold"});
    endtask

    task automatic run_fetch(input logic [31:0] addr, input int flush_at, input string tag);
        logic [31:0] exp_w;
        int          lat;
        bit          got;
        exp_w = {gold_rd(addr + 3), gold_rd(addr + 2), gold_rd(addr + 1), gold_rd(addr)};
        icache_addr = addr; icache_req = 1'b1;
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (i == flush_at) begin
                jump_wrong = 1'b1; icache_req = 1'b0;
            end else begin
                jump_wrong = 1'b0;
            end
            #1;
            if (icache_valid) begin
                got = 1'b1; lat = i; icache_req = 1'b0;
            end
        end
        jump_wrong = 1'b0; icache_req = 1'b0;
        if (flush_at > 0) begin
            chk(32'(got), 32'd0, {tag, "_no_valid"});
        end else begin
            chk(32'(lat), 32'd6, {tag, "_latency"});
            chk(icache_instr, exp_w, {tag, "_instr"});
            @(negedge clk); #1;
            chk(32'(icache_valid), 32'd0, {tag, "_pulse_width"});
            chk(icache_instr, exp_w, {tag, "_instr_hold"});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ld_i, if_i;
        bit          got;
        logic [1:0]  sz;
        logic [31:0] ra;

        rst = 1'b1; rdy = 1'b1; icache_req = 1'b0; icache_addr = 32'd0; jump_wrong = 1'b0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        io_buffer_full = 1'b0;

        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h2003] = 8'hAB;
        golden[32'h100] = 8'h13; golden[32'h101] = 8'h05; golden[32'h102] = 8'h00;
        golden[32'h103] = 8'h00; golden[32'h2003] = 8'hAB;

        repeat (3) @(negedge clk);
        #1;
        chk(mem_a, 32'd0, "reset_mem_a");
        chk(32'(mem_dout), 32'd0, "reset_mem_dout");
        chk(32'(mem_wr), 32'd0, "reset_mem_wr");
        chk(32'(icache_valid), 32'd0, "reset_icache_valid");
        chk(32'(lsb_done), 32'd0, "reset_lsb_done");
        chk(icache_instr, 32'd0, "reset_icache_instr");
        chk(lsb_rdata, 32'd0, "reset_lsb_rdata");
        @(negedge clk);
        rst = 1'b0;

        run_fetch(32'h100, 0, "fetch_word");
        chk(icache_instr, 32'h0000_0513, "fetch_word_const");

        // Both requesters together: byte load first, then the fetch right after.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h2003;
        icache_req = 1'b1; icache_addr = 32'h100;
        ld_i = 0; if_i = 0;
        for (int i = 1; i <= 20 && if_i == 0; i++) begin
            @(negedge clk); #1;
            if (lsb_done) begin
                ld_i = i; lsb_req = 1'b0;
                chk(lsb_rdata, 32'h0000_00AB, "contend_rdata");
            end
            if (icache_valid) begin
                if_i = i; icache_req = 1'b0;
                chk(icache_instr, 32'h0000_0513, "contend_instr");
            end
        end
        lsb_req = 1'b0; icache_req = 1'b0;
        chk(32'(ld_i), 32'd3, "contend_load_first");
        chk(32'(if_i), 32'd9, "contend_fetch_next");
        @(negedge clk);

        run_lsb(1'b1, 2'd1, 32'h40, 32'h0000_1234, "store_half");
        run_lsb(1'b0, 2'd1, 32'h40, 32'd0, "load_half_back");

        run_fetch(32'h200, 3, "flush");
        run_fetch(32'h100, 0, "after_flush");

        hold_at = 2; hold_len = 3;
        run_lsb(1'b0, 2'd2, 32'h80, 32'd0, "rdy_load");
        hold_at = 2; hold_len = 2;
        run_lsb(1'b1, 2'd2, 32'h90, 32'hCAFE_F00D, "rdy_store");
        hold_len = 0;
        run_lsb(1'b0, 2'd2, 32'h90, 32'd0, "rdy_store_readback");

        io_at = 1; io_len = 4;
        run_lsb(1'b1, 2'd0, 32'h30000, 32'h0000_005C, "io_store");
        run_lsb(1'b1, 2'd0, 32'h20000, 32'h0000_0077, "non_io_store");
        io_len = 0;
        run_lsb(1'b0, 2'd0, 32'h30000, 32'd0, "io_readback");

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_fetch(32'($urandom_range(0, 255)) << 2, 0, "rnd_fetch");
            end else begin
                sz = 2'($urandom_range(0, 2));
                ra = 32'($urandom_range(0, 1023));
                run_lsb(1'($urandom_range(0, 1)), sz, ra, $urandom, "rnd_lsb");
            end
        end

        // Reset in the middle of a word store: no pulse, earlier bytes stay written.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h5000;
        lsb_wdata = 32'hA1B2_C3D4;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; lsb_req = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        chk(32'(mem_wr), 32'd0, "rst_mid_mem_wr");
        chk(mem_a, 32'd0, "rst_mid_mem_a");
        chk(lsb_rdata, 32'd0, "rst_mid_lsb_rdata");
        chk(icache_instr, 32'd0, "rst_mid_icache_instr");
        got = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (lsb_done || mem_wr) got = 1'b1;
        end
        chk(32'(got), 32'd0, "rst_mid_no_activity");
        chk(32'(ram_rd(32'h5000)), 32'h0000_00D4, "rst_mid_byte0_kept");
        chk(32'(ram_rd(32'h5002)), 32'(init_byte(32'h5002)), "rst_mid_byte2_untouched");
        chk(32'(ram_rd(32'h5003)), 32'(init_byte(32'h5003)), "rst_mid_byte3_untouched");

        run_fetch(32'h100, 0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
